// File: rtl/ps2_scan_decoder.sv
// PS/2 scan-code set 2 decoder: folds E0/F0/E1 prefix sequences into single key
// events and queues them in a small first-word-fall-through FIFO.
module ps2_scan_decoder #(
  parameter int DEPTH          = 4,
  parameter int ADDR_W         = 2,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int CNT_W          = 21
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic       rx_en,
  output logic       evt_valid,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_brk,
  input  logic       evt_rd,
  output logic       err_tick,
  output logic       ovf_tick
);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } evt_t;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t             state_q, state_d;
  logic [2:0]         skip_q, skip_d;
  logic [CNT_W-1:0]   tmo_q, tmo_d;
  logic               err_q, err_d;
  logic               ovf_q, ovf_d;
  logic               push;
  evt_t               push_evt;

  evt_t               mem_q [DEPTH];
  logic [ADDR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  evt_t               head_q, head_d;
  logic               full, empty, pop, wr_en;

  // Prefix decoder and inter-byte timeout
  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    push     = 1'b0;
    push_evt = '{ext: 1'b0, brk: 1'b0, code: rx_data};
    err_d    = 1'b0;
    tmo_d    = (rx_done_tick || state_q == IDLE) ? '0 : tmo_q + 1'b1;

    if (rx_done_tick) begin
      unique case (state_q)
        IDLE: begin
          unique case (rx_data)
            8'hE0: state_d = EXT;
            8'hF0: state_d = BRK;
            8'hE1: begin
              state_d = SKIP;
              skip_d  = 3'd7;
            end
            8'h00, 8'hFF: err_d = 1'b1;
            8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'hFC: ;
            default: push = 1'b1;
          endcase
        end
        EXT: begin
          unique case (rx_data)
            8'hF0: state_d = EXT_BRK;
            8'hE0: state_d = EXT;
            8'h12, 8'h59: state_d = IDLE;  // fake shift from print-screen / numlock games
            default: begin
              push         = 1'b1;
              push_evt.ext = 1'b1;
              state_d      = IDLE;
            end
          endcase
        end
        BRK: begin
          state_d = IDLE;
          if (rx_data == 8'hE0 || rx_data == 8'hE1 || rx_data == 8'hF0) begin
            err_d = 1'b1;
          end else begin
            push         = 1'b1;
            push_evt.brk = 1'b1;
          end
        end
        EXT_BRK: begin
          state_d = IDLE;
          if (rx_data == 8'hE0 || rx_data == 8'hE1 || rx_data == 8'hF0) begin
            err_d = 1'b1;
          end else if (rx_data != 8'h12 && rx_data != 8'h59) begin
            push         = 1'b1;
            push_evt.ext = 1'b1;
            push_evt.brk = 1'b1;
          end
        end
        SKIP: begin
          // Pause has no break code; the whole 8-byte burst is one make event
          if (skip_q == 3'd1) begin
            push          = 1'b1;
            push_evt.ext  = 1'b1;
            push_evt.code = 8'h77;
            skip_d        = '0;
            state_d       = IDLE;
          end else begin
            skip_d = skip_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tmo_q == TMO_LAST) begin
      state_d = IDLE;
      err_d   = 1'b1;
      tmo_d   = '0;
      skip_d  = '0;
    end
  end

  // FIFO control
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
               (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    pop      = evt_rd && !empty;
    wr_en    = push && (!full || pop);
    ovf_d    = push && full && !pop;
    wr_ptr_d = wr_ptr_q + {{ADDR_W{1'b0}}, wr_en};
    rd_ptr_d = rd_ptr_q + {{ADDR_W{1'b0}}, pop};
    // Head is registered so it can hold its last value once the FIFO drains
    head_d   = head_q;
    if (wr_ptr_d != rd_ptr_d) begin
      if (rd_ptr_d == wr_ptr_q) head_d = push_evt;
      else                      head_d = mem_q[rd_ptr_d[ADDR_W-1:0]];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      skip_q   <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      skip_q   <= skip_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
      if (wr_en) mem_q[wr_ptr_q[ADDR_W-1:0]] <= push_evt;
    end
  end

  assign rx_en     = !full;
  assign evt_valid = !empty;
  assign evt_code  = head_q.code;
  assign evt_ext   = head_q.ext;
  assign evt_brk   = head_q.brk;
  assign err_tick  = err_q;
  assign ovf_tick  = ovf_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Scoreboard bench for ps2_scan_decoder: stimulus queues expected events,
// a negedge consumer pops and compares whatever the FIFO presents.
module tb_ps2_scan_decoder;
  localparam int TMO = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       evt_rd = 1'b0;
  logic       rx_en, evt_valid, evt_ext, evt_brk, err_tick, ovf_tick;
  logic [7:0] evt_code;

  int tests = 0;
  int fails = 0;
  int err_cnt = 0;
  int ovf_cnt = 0;
  int snap;
  logic [9:0] exp_q [$];
  logic [9:0] mon_e;
  bit rd_auto = 1'b0;
  bit force_rd = 1'b0;

  ps2_scan_decoder #(.DEPTH(4), .ADDR_W(2), .TIMEOUT_CYCLES(TMO), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .rx_en(rx_en), .evt_valid(evt_valid), .evt_code(evt_code), .evt_ext(evt_ext),
    .evt_brk(evt_brk), .evt_rd(evt_rd), .err_tick(err_tick), .ovf_tick(ovf_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void ex(input logic [7:0] code, input logic ext, input logic brk);
    exp_q.push_back({ext, brk, code});
  endfunction

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_done_tick = 1'b1;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Consumer / monitor
  always @(negedge clk) begin
    evt_rd = 1'b0;
    if (reset) begin
      if (err_tick) err_cnt++;
      if (ovf_tick) ovf_cnt++;
      if ((rd_auto || force_rd) && evt_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL evt_unexpected: got %0h expected none", {evt_ext, evt_brk, evt_code});
        end else begin
          mon_e = exp_q.pop_front();
          if ({evt_ext, evt_brk, evt_code} !== mon_e) begin
            fails++;
            $display("FAIL evt: got %0h expected %0h", {evt_ext, evt_brk, evt_code}, mon_e);
          end
        end
        evt_rd = 1'b1;
      end
    end
  end

  initial begin
    #12;
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_code", 32'(evt_code), 0);
    chk("rst_flags", {30'd0, evt_ext, evt_brk}, 0);
    chk("rst_ticks", {30'd0, err_tick, ovf_tick}, 0);
    chk("rst_rx_en", 32'(rx_en), 1);
    @(posedge clk); #1 reset = 1'b1;
    idle(2);

    // First-event latency
    ex(8'h1C, 0, 0);
    @(posedge clk); #1;
    rx_data = 8'h1C; rx_done_tick = 1'b1;
    #1 chk("valid_before_edge", 32'(evt_valid), 0);
    @(posedge clk); #1 rx_done_tick = 1'b0;
    chk("valid_latency", 32'(evt_valid), 1);
    chk("head_latency", 32'(evt_code), 32'h1C);
    rd_auto = 1'b1;
    idle(3);

    // Break, extended make/break, fake shifts
    ex(8'h1C, 0, 1); send(8'hF0); send(8'h1C);
    ex(8'h75, 1, 0); send(8'hE0); send(8'h75);
    ex(8'h75, 1, 1); send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'h12);
    send(8'hE0); send(8'hF0); send(8'h12);
    idle(4);
    chk("seq_drain", exp_q.size(), 0);

    // Pause burst
    ex(8'h77, 1, 0);
    foreach (exp_q[i]) ;
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    ex(8'h1C, 0, 0); send(8'h1C);
    idle(4);
    chk("pause_drain", exp_q.size(), 0);

    // Timeout after a lone F0
    snap = err_cnt;
    send(8'hF0);
    idle(TMO + 5);
    chk("timeout_err", err_cnt, snap + 1);
    ex(8'h1C, 0, 0); send(8'h1C);
    idle(4);

    // Overrun bytes
    snap = err_cnt;
    send(8'hFF); idle(3);
    chk("err_ff", err_cnt, snap + 1);
    send(8'h00); idle(3);
    chk("err_00", err_cnt, snap + 2);
    send(8'hAA); idle(3);
    chk("aa_silent", err_cnt, snap + 2);

    // Fill FIFO, drop fifth
    rd_auto = 1'b0;
    idle(2);
    ex(8'h1C, 0, 0); send(8'h1C);
    ex(8'h32, 0, 0); send(8'h32);
    ex(8'h21, 0, 0); send(8'h21);
    chk("rx_en_3", 32'(rx_en), 1);
    ex(8'h23, 0, 0); send(8'h23);
    chk("rx_en_full", 32'(rx_en), 0);
    snap = ovf_cnt;
    send(8'h24); idle(2);
    chk("ovf_drop", ovf_cnt, snap + 1);
    chk("head_full", 32'(evt_code), 32'h1C);

    // Push and pop in the same cycle while full
    snap = ovf_cnt;
    ex(8'h2B, 0, 0);
    @(posedge clk); #1;
    force_rd = 1'b1; rx_data = 8'h2B; rx_done_tick = 1'b1;
    @(posedge clk); #1;
    force_rd = 1'b0; rx_done_tick = 1'b0;
    idle(2);
    chk("full_pushpop_ovf", ovf_cnt, snap);
    chk("full_pushpop_rx_en", 32'(rx_en), 0);
    chk("full_pushpop_head", 32'(evt_code), 32'h32);

    rd_auto = 1'b1;
    idle(10);
    chk("drain_valid", 32'(evt_valid), 0);
    chk("drain_hold", 32'(evt_code), 32'h2B);
    chk("drain_q", exp_q.size(), 0);

    // Reset in the middle of a sequence with a queued event
    rd_auto = 1'b0;
    send(8'h1C);
    send(8'hE0);
    @(posedge clk); #3 reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(evt_valid), 0);
    chk("mid_rst_code", 32'(evt_code), 0);
    chk("mid_rst_rx_en", 32'(rx_en), 1);
    chk("mid_rst_ticks", {30'd0, err_tick, ovf_tick}, 0);
    @(posedge clk); #1 reset = 1'b1;
    rd_auto = 1'b1;
    ex(8'h75, 0, 0); send(8'h75);
    idle(5);
    chk("final_q", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_scan_decoder.md
Name: ps2_scan_decoder

Overview:
- Sits directly downstream of the PS/2 receiver (ps2_rx).
- Consumes received bytes (rx_done_tick + 8-bit data) and decodes scan-code set 2 prefix sequences (E0 extended, F0 break, E1 Pause) into single key events carrying make/break and extended flags.
- Buffers events in a small first-word-fall-through FIFO for the application logic.
- Drives rx_en back to the receiver so new frames are not started while the FIFO is full.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- ADDR_W, 2, log2(DEPTH).
- TIMEOUT_CYCLES, 2000000, clk cycles allowed between bytes of one multi-byte sequence (20 ms at 100 MHz).
- CNT_W, 21, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (reset=0 resets the block immediately).
- rx_done_tick  in  1  one-cycle strobe from the receiver; rx_data is valid in this cycle.
- rx_data  in  8  received byte (receiver dout).
- rx_en  out  1  receiver enable; combinational ~fifo_full.
- evt_valid  out  1  FIFO not empty.
- evt_code  out  8  head-entry scan code.
- evt_ext  out  1  head-entry extended flag (E0 or E1 prefixed).
- evt_brk  out  1  head-entry break (release) flag.
- evt_rd  in  1  pop head entry; ignored when evt_valid=0.
- err_tick  out  1  one-cycle pulse on a protocol error, timeout, or 00/FF overrun byte.
- ovf_tick  out  1  one-cycle pulse when an event is dropped because the FIFO is full.

Behaviour:
- Reset (asynchronous) state:
  - FSM in IDLE; FIFO empty; pointers and timeout counter 0.
  - evt_valid=0, evt_code=0, evt_ext=0, evt_brk=0, err_tick=0, ovf_tick=0, rx_en=1.
- FSM states: IDLE, EXT, BRK, EXT_BRK, SKIP. A byte is processed only in cycles with rx_done_tick=1.
- IDLE:
  - E0 → EXT; F0 → BRK.
  - E1 → SKIP, skip counter = 7.
  - 00 or FF → err_tick, stay in IDLE.
  - AA, FA, FE, EE, FC → discarded silently.
  - Any other byte → push {ext=0, brk=0, code}.
- EXT:
  - F0 → EXT_BRK; E0 → stay in EXT.
  - 12 or 59 (fake shift) → discard, go to IDLE.
  - Other → push {1, 0, code}, go to IDLE.
- BRK:
  - E0, E1 or F0 → err_tick, go to IDLE, no push.
  - Other → push {0, 1, code}, go to IDLE.
- EXT_BRK:
  - 12 or 59 → discard, go to IDLE.
  - E0, E1 or F0 → err_tick, go to IDLE.
  - Other → push {1, 1, code}, go to IDLE.
- SKIP:
  - Each byte decrements the skip counter; contents are not checked.
  - The byte that arrives with counter=1 pushes {1, 0, 8'h77} (Pause make) and returns to IDLE.
  - The sequence E1 14 77 E1 F0 14 F0 77 therefore yields exactly one event.
- Timeout:
  - The counter clears on every rx_done_tick and whenever the FSM is in IDLE; otherwise it increments.
  - On reaching TIMEOUT_CYCLES-1: FSM → IDLE, err_tick pulses, counter clears, and the partial sequence is discarded.
  - If rx_done_tick occurs in the same cycle as the timeout, the byte wins and the timeout is ignored.
- Latency: a push is decided combinationally in the rx_done_tick cycle and written on that clock edge. evt_valid and the head outputs update in the next cycle (1-cycle latency).
- FIFO:
  - First-word fall-through: evt_code/ext/brk always show the head entry. Outputs hold their last value when the FIFO is empty.
  - Pointers are ADDR_W+1 bits wide and wrap modulo 2*DEPTH. full = MSBs differ and low bits equal.
  - Full, push without pop → event dropped, ovf_tick pulses, FSM still advances.
  - Full, push with evt_rd → both accepted, FIFO stays full.
  - Empty, push with evt_rd → push only; the pop is ignored.
- rx_en deasserts whenever the FIFO is full. A frame already in flight can still complete and is then subject to the drop rule.
- err_tick and ovf_tick can pulse in the same cycle.
- Reset asserted mid-sequence or mid-pop: all state clears immediately. Bytes already received in a partial sequence are lost.

Test Plan:
- Bytes 1C, then F0 1C → two events: {code=1C, ext=0, brk=0} then {1C, 0, 1}. evt_valid rises 1 cycle after the first rx_done_tick.
- E0 75, then E0 F0 75 → {75, 1, 0}, {75, 1, 1}. Bytes E0 12, then E0 F0 12 → no events.
- E1 14 77 E1 F0 14 F0 77 → exactly one event {77, 1, 0}; FSM back in IDLE. A following 1C yields {1C, 0, 0}.
- F0 then no bytes for TIMEOUT_CYCLES → err_tick pulses once, FSM in IDLE. A following 1C yields {1C, 0, 0}, not a break.
- Five makes (1C 32 21 23 24) with evt_rd=0, DEPTH=4 → rx_en=0 after the fourth event; the fifth is dropped with ovf_tick. Four pops return 1C 32 21 23 and evt_valid then falls.
- FIFO full, rx_done_tick 2B with evt_rd=1 in the same cycle → no ovf_tick, FIFO stays full, head becomes 32. Separately, byte FF in IDLE → err_tick pulse; reset=0 mid-sequence → all outputs return to their reset values.
